sp_deser: RTL and testbench
===========================

Name: sp_deser

Overview:
- Parametrised serial-to-parallel deserialiser, successor to the team's fixed 8-bit converter.
- Collects WIDTH serial bits gated by bit_ena and supports MSB-first or LSB-first ordering.
- Presents each completed word on a registered output with a valid/ready handshake, replacing the old tri-state output.
- Streams back-to-back words with no dead cycle; flags aborted frames and overruns. Sits between a serial link front end and a parallel consumer.

Parameters:
- WIDTH, 8, word width in bits (>=2).
- MSB_FIRST, 1, 1 = first received bit lands in data_out[WIDTH-1]; 0 = first bit lands in data_out[0].
- CNT_W, $clog2(WIDTH+1), width of bit counter (derived; do not override).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- bit_in  in  1  serial data bit, sampled when bit_ena=1.
- bit_ena  in  1  bit qualifier; a frame is WIDTH consecutive cycles with bit_ena=1.
- data_out  out  WIDTH  last completed word; held stable while data_valid=1.
- data_valid  out  1  word available.
- data_ready  in  1  consumer accepts; transfer when data_valid && data_ready.
- frame_err  out  1  one-cycle pulse: frame aborted mid-word.
- overrun  out  1  sticky: completed word dropped because output was full.
- busy  out  1  1 while 1..WIDTH-1 bits of the current frame are captured.
- bit_cnt  out  CNT_W  bits captured in current frame (0..WIDTH-1).

Behaviour:
- Reset (rst=1 at edge): data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0, bit_cnt=0, shift register=0. Reset mid-frame discards the partial word; reset wins over all other inputs.
- Capture: each edge with bit_ena=1 shifts bit_in into shift register (left shift if MSB_FIRST, right shift otherwise) and increments bit_cnt.
- Completion: the edge sampling bit number WIDTH forms the word from the shift register plus the current bit_in.
  - If the output is free, or data_valid && data_ready on that same edge: load data_out and set data_valid=1.
  - Latency: data_valid high in the cycle after the WIDTH-th sampling edge.
  - bit_cnt returns to 0 on the completing edge. If bit_ena stays 1, the next edge is bit 0 of the next word (no gap cycle).
- Handshake: data_valid && data_ready at an edge with no simultaneous completion clears data_valid. data_out is unchanged until the next load.
- Overrun: completion while data_valid=1 and data_ready=0 drops the new word, sets overrun=1 (cleared only by rst), and leaves data_out/data_valid untouched.
- Abort: bit_ena=0 while bit_cnt is in 1..WIDTH-1 discards the partial word, sets bit_cnt=0, and pulses frame_err=1 for exactly one cycle. bit_ena=0 with bit_cnt=0 is idle and produces no error.
- FSM (2 states):
  - IDLE (bit_cnt=0): bit_ena=1 -> SHIFT.
  - SHIFT: bit_ena=1 and bit_cnt<WIDTH-1 -> SHIFT.
  - SHIFT: bit_ena=1 on the last bit -> IDLE, or stays SHIFT for the next word's first bit only via IDLE->SHIFT on the following edge.
  - SHIFT: bit_ena=0 -> IDLE with frame_err.
  - busy = (state==SHIFT).
- No combinational path from any input to any output.

Decomposition:
- Package sp_pkg holds:
  - state encoding (ST_IDLE=1'b0, ST_SHIFT=1'b1);
  - YES/NO constants;
  - a function for the shift direction given MSB_FIRST.
- One sub-module, sp_shift_reg (WIDTH, MSB_FIRST): shift register with shift-enable and clear, exposing the next-word value.
- Counter, FSM and handshake/output register stay in sp_deser.

Test Plan:
- WIDTH=8, MSB_FIRST=1: bit_ena=1 for 8 cycles with bits 0,0,0,1,0,0,1,0 and data_ready=1 -> data_out=0x12, data_valid=1 for one cycle after the 8th edge, frame_err=0.
- WIDTH=8, MSB_FIRST=0: same bit sequence -> data_out=0x48.
- Back-to-back: 16 consecutive bits 0xA5 then 0x3C (MSB-first), data_ready=1 -> two valid words 0xA5, 0x3C exactly 8 cycles apart, no gap.
- Overrun: data_ready=0, send 0xA5 then 0x3C -> data_out stays 0xA5, data_valid=1, overrun=1. Then data_ready=1 -> one transfer of 0xA5, overrun remains 1 until rst.
- Abort: 5 bits then bit_ena=0 -> frame_err high exactly 1 cycle, bit_cnt=0, no data_valid. A following full frame 0xFF -> data_out=0xFF.
- Reset mid-frame: rst=1 after 3 bits -> all outputs 0 next cycle. A following full frame 0x81 -> data_out=0x81. Also: completion coinciding with data_ready while valid -> data_valid stays 1, data_out updates to the new word.

Source files
------------

// File: rtl/sp_pkg.sv
// Shared types and constants for the serial-to-parallel deserialiser.
package sp_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } shift_dir_e;

  localparam logic YES = 1'b1;
  localparam logic NO  = 1'b0;

  // MSB-first words fill from the top, so new bits enter on the right (left shift).
  function automatic shift_dir_e shift_dir(input bit msb_first);
    return msb_first ? DIR_LEFT : DIR_RIGHT;
  endfunction

endpackage

// File: rtl/sp_deser_if.sv
// Serial input / parallel output bundle between link front end, deserialiser and consumer.
interface sp_deser_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
);
  logic             bit_in;
  logic             bit_ena;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             frame_err;
  logic             overrun;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    input  bit_in, bit_ena, data_ready,
    output data_out, data_valid, frame_err, overrun, busy, bit_cnt
  );

  modport slave (
    output bit_in, bit_ena, data_ready,
    input  data_out, data_valid, frame_err, overrun, busy, bit_cnt
  );
endinterface

// File: rtl/sp_shift_reg.sv
// Direction-configurable shift register; exposes the word that would result from shifting in bit_in now.
module sp_shift_reg
  import sp_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             bit_in,
  output logic [WIDTH-1:0] next_word_c
);

  localparam shift_dir_e DIR = shift_dir(MSB_FIRST);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    if (DIR == DIR_LEFT) next_word_c = {sr_q[WIDTH-2:0], bit_in};
    else                 next_word_c = {bit_in, sr_q[WIDTH-1:1]};
  end

  // Clear wins so a completed or aborted frame never leaks into the next one.
  always_comb begin
    sr_d = sr_q;
    if (clr)           sr_d = '0;
    else if (shift_en) sr_d = next_word_c;
  end

  always_ff @(posedge clk) begin
    if (rst) sr_q <= '0;
    else     sr_q <= sr_d;
  end

endmodule

// File: rtl/sp_deser.sv
// Serial-to-parallel deserialiser: bit counter, frame FSM and valid/ready output register.
module sp_deser
  import sp_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = $clog2(WIDTH + 1)
) (
  input logic           clk,
  input logic           rst,
  sp_deser_if.master    bus
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic             shift_en;
  logic             sr_clr;
  logic [WIDTH-1:0] next_word;
  logic             xfer;

  sp_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk         (clk),
    .rst         (rst),
    .shift_en    (shift_en),
    .clr         (sr_clr),
    .bit_in      (bus.bit_in),
    .next_word_c (next_word)
  );

  assign xfer = valid_q & bus.data_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ferr_d   = NO;
    ovr_d    = ovr_q;
    shift_en = NO;
    sr_clr   = NO;

    if (xfer) valid_d = NO;

    if (bus.bit_ena) begin
      shift_en = YES;
      if (cnt_q == LAST_BIT) begin
        // Word complete; a same-edge transfer frees the output slot for it.
        cnt_d   = '0;
        state_d = ST_IDLE;
        sr_clr  = YES;
        if (!valid_q || xfer) begin
          data_d  = next_word;
          valid_d = YES;
        end else begin
          ovr_d = YES;
        end
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = ST_SHIFT;
      end
    end else if (state_q == ST_SHIFT) begin
      cnt_d   = '0;
      state_d = ST_IDLE;
      sr_clr  = YES;
      ferr_d  = YES;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= NO;
      ferr_q  <= NO;
      ovr_q   <= NO;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = (state_q == ST_SHIFT);
  assign bus.bit_cnt    = cnt_q;

endmodule

// File: tb/tb_sp_deser.sv
// Directed bench for sp_deser: MSB-first instance is fully checked, an LSB-first instance checks bit ordering.
module tb_sp_deser;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic clk;
  logic rst;
  logic bit_in;
  logic bit_ena;
  logic data_ready;

  int n_checks;
  int n_fails;

  sp_deser_if #(.WIDTH(WIDTH)) bus_m ();
  sp_deser_if #(.WIDTH(WIDTH)) bus_l ();

  assign bus_m.bit_in     = bit_in;
  assign bus_m.bit_ena    = bit_ena;
  assign bus_m.data_ready = data_ready;
  assign bus_l.bit_in     = bit_in;
  assign bus_l.bit_ena    = bit_ena;
  assign bus_l.data_ready = data_ready;

  sp_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (bus_m)
  );

  sp_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (bus_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_ena = 1'b1;
    bit_in  = b;
    tick();
  endtask

  // Sends the top n bits of v, most significant first.
  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
  endtask

  task automatic idle();
    bit_ena = 1'b0;
    bit_in  = 1'b0;
    tick();
  endtask

  task automatic check_all(input string tag, input logic [7:0] d, input logic v,
                           input logic fe, input logic ov, input logic bz, input logic [CNT_W-1:0] bc);
    check({tag, ".data_out"},   32'(bus_m.data_out),   32'(d));
    check({tag, ".data_valid"}, 32'(bus_m.data_valid), 32'(v));
    check({tag, ".frame_err"},  32'(bus_m.frame_err),  32'(fe));
    check({tag, ".overrun"},    32'(bus_m.overrun),    32'(ov));
    check({tag, ".busy"},       32'(bus_m.busy),       32'(bz));
    check({tag, ".bit_cnt"},    32'(bus_m.bit_cnt),    32'(bc));
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    rst        = 1'b1;
    bit_in     = 1'b0;
    bit_ena    = 1'b0;
    data_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

    // Basic word 0x12 with consumer ready; LSB-first instance sees 0x48.
    send_bits(8'h12, 3);
    check("mid.busy", 32'(bus_m.busy), 32'd1);
    check("mid.bit_cnt", 32'(bus_m.bit_cnt), 32'd3);
    send_bits(8'h12 << 3, 5);
    check_all("w12", 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    check("lsb.data_out", 32'(bus_l.data_out), 32'h48);
    check("lsb.data_valid", 32'(bus_l.data_valid), 32'd1);
    idle();
    check("w12.drop_valid", 32'(bus_m.data_valid), 32'd0);
    check("w12.hold_data", 32'(bus_m.data_out), 32'h12);

    // Back-to-back 0xA5, 0x3C with no gap cycle.
    send_bits(8'hA5, 8);
    check_all("b2b.a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    send_bit(1'b0);
    check("b2b.bit0_cnt", 32'(bus_m.bit_cnt), 32'd1);
    check("b2b.bit0_valid", 32'(bus_m.data_valid), 32'd0);
    send_bits(8'h3C << 1, 7);
    check_all("b2b.3c", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    idle();

    // Overrun: second word dropped while output is full.
    data_ready = 1'b0;
    send_bits(8'hA5, 8);
    check_all("ovr.a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    send_bits(8'h3C, 8);
    check_all("ovr.3c", 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    idle();
    check("ovr.hold_valid", 32'(bus_m.data_valid), 32'd1);
    data_ready = 1'b1;
    idle();
    check_all("ovr.drain", 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0);

    // Abort after 5 bits, then a clean 0xFF.
    send_bits(8'hFF, 5);
    idle();
    check_all("abort", 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    idle();
    check("abort.pulse_end", 32'(bus_m.frame_err), 32'd0);
    idle();
    check("abort.idle_no_err", 32'(bus_m.frame_err), 32'd0);
    send_bits(8'hFF, 8);
    check_all("abort.ff", 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0);
    idle();

    // Reset mid-frame clears everything including sticky overrun.
    send_bits(8'hE0, 3);
    rst     = 1'b1;
    bit_ena = 1'b1;
    bit_in  = 1'b1;
    tick();
    rst = 1'b0;
    bit_ena = 1'b0;
    check_all("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    data_ready = 1'b0;
    send_bits(8'h81, 8);
    check_all("w81", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);

    // Completion on the same edge as a transfer reloads the output.
    send_bits(8'h5A, 7);
    check("coin.hold", 32'(bus_m.data_out), 32'h81);
    data_ready = 1'b1;
    send_bit(1'b0);
    check_all("coin.5a", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    idle();
    check("coin.drain", 32'(bus_m.data_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
